// File: rtl/sti_pkg.sv
// Shared types and constants for the STI load sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sti_pkg;

    localparam int STI_WORD_W = 16;
    localparam int WD_W       = 7;

    localparam logic [1:0] LEN8  = 2'b00;
    localparam logic [1:0] LEN16 = 2'b01;
    localparam logic [1:0] LEN24 = 2'b10;
    localparam logic [1:0] LEN32 = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_SHIFT      = 3'd3,
        ST_GAP        = 3'd4,
        ST_DRAIN      = 3'd5,
        ST_DONE       = 3'd6,
        ST_ERR        = 3'd7
    } state_t;

    typedef struct packed {
        logic [STI_WORD_W-1:0] data;
        logic [1:0]            length;
        logic                  fill;
        logic                  msb;
        logic                  low;
    } sti_word_t;

endpackage

// File: rtl/sti_load_sched_if.sv
// Requester, serializer and status signals of the STI load sequencer.
// Latency: n/a (wiring only).
// Backpressure: rq_valid/rq_ready handshake per requester.
interface sti_load_sched_if #(parameter int N_REQ = 2);
    import sti_pkg::*;

    logic [N_REQ-1:0]            rq_valid;
    logic [N_REQ-1:0]            rq_ready;
    logic [STI_WORD_W*N_REQ-1:0] rq_data;
    logic [2*N_REQ-1:0]          rq_length;
    logic [N_REQ-1:0]            rq_fill;
    logic [N_REQ-1:0]            rq_msb;
    logic [N_REQ-1:0]            rq_low;
    logic [N_REQ-1:0]            rq_last;

    logic                        load;
    logic [STI_WORD_W-1:0]       pi_data;
    logic [1:0]                  pi_length;
    logic                        pi_fill;
    logic                        pi_msb;
    logic                        pi_low;
    logic                        pi_end;
    logic                        so_valid;
    logic                        oem_finish;

    logic                        busy;
    logic                        done;
    logic                        err_timeout;
    logic [2:0]                  cur_src;
    logic [7:0]                  word_cnt;

    // Environment side: requesters plus serializer feedback.
    modport master (
        output rq_valid, rq_data, rq_length, rq_fill, rq_msb, rq_low, rq_last,
        output so_valid, oem_finish,
        input  rq_ready, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        input  busy, done, err_timeout, cur_src, word_cnt
    );

    // Sequencer side.
    modport slave (
        input  rq_valid, rq_data, rq_length, rq_fill, rq_msb, rq_low, rq_last,
        input  so_valid, oem_finish,
        output rq_ready, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
        output busy, done, err_timeout, cur_src, word_cnt
    );

endinterface

// File: rtl/sti_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
// Latency: grant is combinational; pointer moves on the handshake edge.
// Backpressure: no grant while en is low; pointer holds when nothing is accepted.
module sti_rr_arbiter #(
    parameter int N_REQ = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             en,
    input  logic             adv,
    output logic [N_REQ-1:0] grant,
    output logic [2:0]       gnt_idx
);

    logic [2:0] ptr;
    logic       found;

    // First requester at or above the pointer wins, wrapping past N_REQ-1.
    always_comb begin
        int j;
        grant   = '0;
        gnt_idx = '0;
        found   = 1'b0;
        j       = 0;
        for (int i = 0; i < N_REQ; i++) begin
            j = int'(ptr) + i;
            if (j >= N_REQ) j = j - N_REQ;
            if (en && !found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                gnt_idx  = 3'(j);
            end
        end
    end

    // Pointer moves just past the accepted requester.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (adv) begin
            ptr <= (gnt_idx == 3'(N_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
        end
    end

endmodule

// File: rtl/sti_load_sched.sv
// Picks one STI word per round, loads it into the serializer and tracks completion.
// Latency: load pulses 1 cycle after the rq handshake; next grant no earlier than one GAP cycle after shifting.
// Backpressure: rq_ready only in IDLE; stalled serializer is caught by per-state watchdogs.
module sti_load_sched
    import sti_pkg::*;
#(
    parameter int N_REQ    = 2,
    parameter int START_TO = 4,
    parameter int SHIFT_TO = 40,
    parameter int DRAIN_TO = 80
) (
    input  logic             clk,
    input  logic             reset,
    sti_load_sched_if.slave  bus
);

    localparam logic [WD_W-1:0] START_LIM = WD_W'(START_TO - 1);
    localparam logic [WD_W-1:0] SHIFT_LIM = WD_W'(SHIFT_TO - 1);
    localparam logic [WD_W-1:0] DRAIN_LIM = WD_W'(DRAIN_TO - 1);

    state_t            state, state_nxt;
    logic [WD_W-1:0]   wd;
    sti_word_t         word_q, sel_word;
    logic              last_q, sel_last;
    logic [2:0]        cur_src_q, gnt_idx;
    logic [7:0]        word_cnt_q;
    logic [N_REQ-1:0]  grant;
    logic              grant_en, hs;

    // A stray so_valid in IDLE is a protocol error, so no grant that cycle.
    assign grant_en = (state == ST_IDLE) && !bus.so_valid;
    assign hs       = |grant;

    sti_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (bus.rq_valid),
        .en      (grant_en),
        .adv     (hs),
        .grant   (grant),
        .gnt_idx (gnt_idx)
    );

    // Mux the granted requester's fields using the one-hot grant.
    always_comb begin
        sel_word = '0;
        sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_word.data   = bus.rq_data[i*STI_WORD_W +: STI_WORD_W];
                sel_word.length = bus.rq_length[i*2 +: 2];
                sel_word.fill   = bus.rq_fill[i];
                sel_word.msb    = bus.rq_msb[i];
                sel_word.low    = bus.rq_low[i];
                sel_last        = bus.rq_last[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state: handshake, serializer progress and watchdog limits.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:       if (bus.so_valid)            state_nxt = ST_ERR;
                           else if (hs)                 state_nxt = ST_LOAD;
            ST_LOAD:                                    state_nxt = ST_WAIT_START;
            ST_WAIT_START: if (bus.so_valid)            state_nxt = ST_SHIFT;
                           else if (wd == START_LIM)    state_nxt = ST_ERR;
            ST_SHIFT:      if (!bus.so_valid)           state_nxt = last_q ? ST_DRAIN : ST_GAP;
                           else if (wd == SHIFT_LIM)    state_nxt = ST_ERR;
            ST_GAP:        state_nxt = bus.so_valid ? ST_ERR : ST_IDLE;
            ST_DRAIN:      if (bus.oem_finish)          state_nxt = ST_DONE;
                           else if (wd == DRAIN_LIM)    state_nxt = ST_ERR;
            default:       state_nxt = state;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        bus.load        = (state == ST_LOAD);
        bus.busy        = !(state inside {ST_IDLE, ST_DONE, ST_ERR});
        bus.done        = (state == ST_DONE);
        bus.err_timeout = (state == ST_ERR);
        bus.pi_end      = last_q && (state inside {ST_LOAD, ST_WAIT_START, ST_SHIFT, ST_DRAIN});
    end

    // Watchdog restarts on every state change and saturates while a state holds.
    always_ff @(posedge clk) begin
        if (!reset)                  wd <= '0;
        else if (state_nxt != state) wd <= '0;
        else if (wd != '1)           wd <= wd + WD_W'(1);
    end

    // Capture the accepted word; it stays on pi_* until the next acceptance.
    always_ff @(posedge clk) begin
        if (!reset) begin
            word_q     <= '0;
            last_q     <= 1'b0;
            cur_src_q  <= '0;
            word_cnt_q <= '0;
        end else if (hs) begin
            word_q    <= sel_word;
            last_q    <= sel_last;
            cur_src_q <= gnt_idx;
            if (word_cnt_q != 8'hFF) word_cnt_q <= word_cnt_q + 8'd1;
        end
    end

    assign bus.rq_ready  = grant;
    assign bus.pi_data   = word_q.data;
    assign bus.pi_length = word_q.length;
    assign bus.pi_fill   = word_q.fill;
    assign bus.pi_msb    = word_q.msb;
    assign bus.pi_low    = word_q.low;
    assign bus.cur_src   = cur_src_q;
    assign bus.word_cnt  = word_cnt_q;

endmodule
